tmr_vote_pipe: RTL and testbench
================================

// Module: tmr_vote_pipe
// PURPOSE
//   Parametrised, pipelined triple-modular-redundancy bitwise majority voter.
//   It registers three redundant WIDTH-bit channels, votes each bit 2-of-3 and registers the result.
//   It also tracks per-channel disagreement in saturating counters.
//   It is the standard register->logic->register target for the combinational-extractor and fault-emulation flows.
// PARAMETERS
//   WIDTH  8  data width of each channel and of the voted output
//   CNT_W  8  width of each per-channel error counter (saturating)
// PORTS
//   clk        in   1      sole clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      a/b/c carry a sample this cycle
//   a          in   WIDTH  channel A
//   b          in   WIDTH  channel B
//   c          in   WIDTH  channel C
//   clr_cnt    in   1      synchronous clear of all error counters and sticky flag
//   out_valid  out  1      g carries a voted sample
//   g          out  WIDTH  voted word, bit i = maj(a[i],b[i],c[i])
//   mismatch   out  1      any channel disagreed on the sample now on g
//   err_sticky out  1      set by any mismatch, held until clr_cnt or rst
//   err_cnt_a  out  CNT_W  samples on which A differed from the vote
//   err_cnt_b  out  CNT_W  samples on which B differed from the vote
//   err_cnt_c  out  CNT_W  samples on which C differed from the vote
// BEHAVIOUR
//   - Reset: every register clears asynchronously on rst=1.
//     Outputs read out_valid=0, g=0, mismatch=0, err_sticky=0, err_cnt_*=0.
//   - Stage 1 (input register): on a clk edge with in_valid=1, capture a,b,c into ra,rb,rc and set v1=1.
//     With in_valid=0, v1=0 and ra/rb/rc hold their values.
//   - Vote (combinational on stage 1): m = (rb&rc) | (ra&(rb|rc)).
//     Per-channel difference flags: da=|(ra^m), db=|(rb^m), dc=|(rc^m).
//   - Stage 2 (output register): out_valid<=v1.
//     When v1=1: g<=m and mismatch<=da|db|dc. When v1=0: g holds and mismatch<=0.
//   - Latency: sample at in_valid edge N appears on g/out_valid after edge N+1 (2-cycle latency).
//     Throughput is one sample per clock; there is no backpressure.
//   - Counters update at the same edge as stage 2, only when v1=1. err_cnt_x increments by 1 if dx=1.
//     Counters saturate at 2^CNT_W-1 and never wrap.
//   - err_sticky is set at the same edge as any mismatch is registered.
//   - clr_cnt=1 zeroes all counters and err_sticky at the edge. Clear wins over a same-cycle increment.
//     clr_cnt does not affect the data path or out_valid.
//   - Multi-bit disagreement within one sample counts once per channel.
//     A single bit flip is counted only on the faulty channel.
//     If all three channels differ pairwise on a bit, the vote follows majority per bit.
//     Each channel that differs from m on any bit is counted.
//   - rst asserted mid-stream discards in-flight samples.
//     The first out_valid after release is 2 edges after the first accepted in_valid.
// CONFIGURATION
//   TMR_VOTE_FAULT_INJECT_EN defined:
//     - Adds inputs inj_en (1 bit) and inj_a, inj_b, inj_c (WIDTH bits each).
//     - When inj_en=1, stage 1 captures a^inj_a, b^inj_b, c^inj_c. Counters then see the injected faults.
//     - The injection masks are not registered separately.
//   TMR_VOTE_FAULT_INJECT_EN undefined:
//     - These ports do not exist.
//     - Stage 1 captures a,b,c unmodified.
// TESTING
//   1. rst pulse mid-run -> all outputs 0 immediately.
//      in_valid at edge 1 after release -> out_valid first high after edge 2.
//   2. a=b=c=8'hA5, in_valid=1 for 4 cycles -> g=8'hA5 with 2-cycle latency, mismatch=0, counters stay 0.
//   3. a=8'h00, b=c=8'hFF -> g=8'hFF, mismatch=1, err_cnt_a=1, err_cnt_b=err_cnt_c=0, err_sticky=1.
//   4. CNT_W=2, force B faulty for 5 valid samples -> err_cnt_b goes 1,2,3,3,3.
//      Then clr_cnt with B still faulty -> err_cnt_b=0 and err_sticky=0 after that edge.
//   5. a=8'h0F, b=8'h33, c=8'h55 -> g=8'h17, mismatch=1, all three counters +1.
//   6. Macro defined: a=b=c=8'h00, inj_en=1, inj_c=8'h80 -> g=8'h00, err_cnt_c=1.
//      The same stimulus with inj_en=0 leaves the counters unchanged.

Source files
------------

// File: rtl/tmr_vote_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tmr_vote_pipe
//  Brief    : Pipelined TMR bitwise 2-of-3 voter with per-channel saturating
//             disagreement counters and a sticky error flag.
//             Optional fault injection on the stage-1 capture is enabled by
//             defining TMR_VOTE_FAULT_INJECT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tmr_vote_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             clr_cnt,
`ifdef TMR_VOTE_FAULT_INJECT_EN
    input  logic             inj_en,
    input  logic [WIDTH-1:0] inj_a,
    input  logic [WIDTH-1:0] inj_b,
    input  logic [WIDTH-1:0] inj_c,
`endif
    output logic             out_valid,
    output logic [WIDTH-1:0] g,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt_a,
    output logic [CNT_W-1:0] err_cnt_b,
    output logic [CNT_W-1:0] err_cnt_c
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] w_cap_a;
    logic [WIDTH-1:0] w_cap_b;
    logic [WIDTH-1:0] w_cap_c;

`ifdef TMR_VOTE_FAULT_INJECT_EN
    // Masks flip bits only on the way into stage 1; they are never stored.
    assign w_cap_a = inj_en ? (a ^ inj_a) : a;
    assign w_cap_b = inj_en ? (b ^ inj_b) : b;
    assign w_cap_c = inj_en ? (c ^ inj_c) : c;
`else
    assign w_cap_a = a;
    assign w_cap_b = b;
    assign w_cap_c = c;
`endif

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;
    logic             r_v1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a  <= '0;
            r_b  <= '0;
            r_c  <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_a <= w_cap_a;
                r_b <= w_cap_b;
                r_c <= w_cap_c;
            end
        end
    end

    logic [WIDTH-1:0] w_m;
    logic [2:0]       w_diff;
    logic             w_any;

    assign w_m       = (r_b & r_c) | (r_a & (r_b | r_c));
    assign w_diff[0] = |(r_a ^ w_m);
    assign w_diff[1] = |(r_b ^ w_m);
    assign w_diff[2] = |(r_c ^ w_m);
    assign w_any     = |w_diff;

    logic [WIDTH-1:0] r_g;
    logic             r_out_valid;
    logic             r_mismatch;
    logic             r_sticky;
    logic [CNT_W-1:0] r_cnt [3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_g         <= '0;
            r_out_valid <= 1'b0;
            r_mismatch  <= 1'b0;
        end else begin
            r_out_valid <= r_v1;
            if (r_v1) begin
                r_g        <= w_m;
                r_mismatch <= w_any;
            end else begin
                r_mismatch <= 1'b0;
            end
        end
    end

    // Clear takes priority over any increment landing on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (clr_cnt) begin
            r_sticky <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (r_v1) begin
            if (w_any) begin
                r_sticky <= 1'b1;
            end
            for (int i = 0; i < 3; i++) begin
                if (w_diff[i] && (r_cnt[i] != c_CNT_MAX)) begin
                    r_cnt[i] <= r_cnt[i] + c_CNT_ONE;
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign g          = r_g;
    assign mismatch   = r_mismatch;
    assign err_sticky = r_sticky;
    assign err_cnt_a  = r_cnt[0];
    assign err_cnt_b  = r_cnt[1];
    assign err_cnt_c  = r_cnt[2];

endmodule
`default_nettype wire

// File: tb/tb_tmr_vote_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tmr_vote_pipe
//  Brief    : Directed, table-driven self-checking bench for tmr_vote_pipe.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tmr_vote_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] a, b, c;
    logic       clr_cnt;
    logic       out_valid;
    logic [7:0] g;
    logic       mismatch;
    logic       err_sticky;
    logic [7:0] err_cnt_a, err_cnt_b, err_cnt_c;

    logic       in_valid2;
    logic [7:0] a2, b2, c2;
    logic       clr2;
    logic       out_valid2;
    logic [7:0] g2;
    logic       mismatch2;
    logic       sticky2;
    logic [1:0] cnt_a2, cnt_b2, cnt_c2;

`ifdef TMR_VOTE_FAULT_INJECT_EN
    logic       inj_en;
    logic [7:0] inj_a, inj_b, inj_c;
`endif

    int checks;
    int errors;

    tmr_vote_pipe #(.WIDTH(8), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .a          (a),
        .b          (b),
        .c          (c),
        .clr_cnt    (clr_cnt),
`ifdef TMR_VOTE_FAULT_INJECT_EN
        .inj_en     (inj_en),
        .inj_a      (inj_a),
        .inj_b      (inj_b),
        .inj_c      (inj_c),
`endif
        .out_valid  (out_valid),
        .g          (g),
        .mismatch   (mismatch),
        .err_sticky (err_sticky),
        .err_cnt_a  (err_cnt_a),
        .err_cnt_b  (err_cnt_b),
        .err_cnt_c  (err_cnt_c)
    );

    tmr_vote_pipe #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid2),
        .a          (a2),
        .b          (b2),
        .c          (c2),
        .clr_cnt    (clr2),
`ifdef TMR_VOTE_FAULT_INJECT_EN
        .inj_en     (1'b0),
        .inj_a      (8'h00),
        .inj_b      (8'h00),
        .inj_c      (8'h00),
`endif
        .out_valid  (out_valid2),
        .g          (g2),
        .mismatch   (mismatch2),
        .err_sticky (sticky2),
        .err_cnt_a  (cnt_a2),
        .err_cnt_b  (cnt_b2),
        .err_cnt_c  (cnt_c2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] g;
        logic       mm;
        logic       ea;
        logic       eb;
        logic       ec;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_ca, exp_cb, exp_cc;
        logic exp_st;
        int base_c;

        checks = 0;
        errors = 0;

        //          a      b      c      g      mm    ea    eb    ec
        tbl[0] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h0F, 8'h33, 8'h55, 8'h17, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[3] = '{8'hFF, 8'hFE, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{8'h3C, 8'h3C, 8'hC3, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{8'h12, 8'h34, 8'h12, 8'h12, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{8'hF0, 8'h0F, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c = '0; clr_cnt = 1'b0;
        in_valid2 = 1'b0; a2 = '0; b2 = '0; c2 = '0; clr2 = 1'b0;
`ifdef TMR_VOTE_FAULT_INJECT_EN
        inj_en = 1'b0; inj_a = '0; inj_b = '0; inj_c = '0;
`endif
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_g", 32'(g), 32'd0);
        chk("rst_mismatch", 32'(mismatch), 32'd0);
        chk("rst_sticky", 32'(err_sticky), 32'd0);
        chk("rst_cnt_a", 32'(err_cnt_a), 32'd0);
        chk("rst_cnt_b", 32'(err_cnt_b), 32'd0);
        chk("rst_cnt_c", 32'(err_cnt_c), 32'd0);
        rst = 1'b0;
        tick();

        // Four back-to-back identical samples: latency 2, no mismatch.
        a = 8'hA5; b = 8'hA5; c = 8'hA5; in_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 4) in_valid = 1'b0;
            chk($sformatf("stream_valid_%0d", k), 32'(out_valid), (k >= 2 && k <= 5) ? 32'd1 : 32'd0);
            if (k >= 2 && k <= 5) begin
                chk($sformatf("stream_g_%0d", k), 32'(g), 32'hA5);
                chk($sformatf("stream_mm_%0d", k), 32'(mismatch), 32'd0);
            end
        end
        chk("stream_cnt_a", 32'(err_cnt_a), 32'd0);
        chk("stream_cnt_b", 32'(err_cnt_b), 32'd0);
        chk("stream_cnt_c", 32'(err_cnt_c), 32'd0);

        exp_ca = 0; exp_cb = 0; exp_cc = 0; exp_st = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a = tbl[i].a; b = tbl[i].b; c = tbl[i].c; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
            exp_ca += int'(tbl[i].ea);
            exp_cb += int'(tbl[i].eb);
            exp_cc += int'(tbl[i].ec);
            exp_st |= tbl[i].mm;
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_g", i), 32'(g), 32'(tbl[i].g));
            chk($sformatf("vec%0d_mm", i), 32'(mismatch), 32'(tbl[i].mm));
            chk($sformatf("vec%0d_cnt_a", i), 32'(err_cnt_a), 32'(exp_ca));
            chk($sformatf("vec%0d_cnt_b", i), 32'(err_cnt_b), 32'(exp_cb));
            chk($sformatf("vec%0d_cnt_c", i), 32'(err_cnt_c), 32'(exp_cc));
            chk($sformatf("vec%0d_sticky", i), 32'(err_sticky), 32'(exp_st));
        end
        tick();
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_mm", 32'(mismatch), 32'd0);
        chk("idle_g_hold", 32'(g), 32'hFF);

`ifdef TMR_VOTE_FAULT_INJECT_EN
        base_c = int'(err_cnt_c);
        a = 8'h00; b = 8'h00; c = 8'h00; inj_en = 1'b1; inj_c = 8'h80; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; inj_en = 1'b0;
        tick();
        chk("inj_g", 32'(g), 32'h00);
        chk("inj_cnt_c", 32'(err_cnt_c), 32'(base_c + 1));
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("noinj_cnt_c", 32'(err_cnt_c), 32'(base_c + 1));
        inj_c = 8'h00;
`else
        base_c = 0;
`endif

        // Reset mid-stream: asynchronous clear, in-flight sample discarded.
        a = 8'h11; b = 8'h11; c = 8'h22; in_valid = 1'b1;
        tick();
        #2;
        rst = 1'b1; in_valid = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_g", 32'(g), 32'd0);
        chk("arst_sticky", 32'(err_sticky), 32'd0);
        chk("arst_cnt_a", 32'(err_cnt_a), 32'd0);
        chk("arst_cnt_b", 32'(err_cnt_b), 32'd0);
        chk("arst_cnt_c", 32'(err_cnt_c), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_idle", 32'(out_valid), 32'd0);
        a = 8'h5A; b = 8'h5A; c = 8'h5A; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post_rst_e1", 32'(out_valid), 32'd0);
        tick();
        chk("post_rst_e2", 32'(out_valid), 32'd1);
        chk("post_rst_g", 32'(g), 32'h5A);

        // CNT_W=2 instance: B faulty every cycle, counter saturates at 3.
        a2 = 8'h00; b2 = 8'hFF; c2 = 8'h00; in_valid2 = 1'b1;
        tick();
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("sat_cnt_b_%0d", k), 32'(cnt_b2), (k < 3) ? 32'(k) : 32'd3);
        end
        chk("sat_cnt_a", 32'(cnt_a2), 32'd0);
        chk("sat_cnt_c", 32'(cnt_c2), 32'd0);
        chk("sat_g", 32'(g2), 32'h00);
        chk("sat_sticky", 32'(sticky2), 32'd1);
        clr2 = 1'b1;
        tick();
        clr2 = 1'b0;
        chk("clr_cnt_b", 32'(cnt_b2), 32'd0);
        chk("clr_sticky", 32'(sticky2), 32'd0);
        chk("clr_keeps_valid", 32'(out_valid2), 32'd1);
        tick();
        chk("after_clr_cnt_b", 32'(cnt_b2), 32'd1);
        chk("after_clr_sticky", 32'(sticky2), 32'd1);
        in_valid2 = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
